// File: rtl/mdc_commutator.sv
// ---------------------------------------------------------------------------
// mdc_commutator
//   Radix-2 MDC delay-commutator. Two sample lines enter per accepted cycle.
//   The lower line is delayed DEPTH samples (S2). An internally generated
//   phase selects whether the upper line or the delayed lower line is routed
//   into the upper delay line (S1). The other one goes straight to the lower
//   output. Output pairs therefore sit DEPTH samples apart, as the next
//   butterfly expects.
//
//   Ports
//     clk, rst_n   single rising-edge clock, async active-low reset
//     in_valid     line1/line2 carry a sample this cycle (the advance enable)
//     frame_start  forces the current sample to phase 0 (only with in_valid)
//     bypass       registered pass-through; internal state keeps advancing
//     line1/line2  signed upper/lower input lines
//     out_valid    line1_o/line2_o hold a valid pair
//     line1_o/2_o  signed upper/lower output lines
// ---------------------------------------------------------------------------

// One delay line: DEPTH registers that shift only when en is high.
module mdc_dline #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  logic [DEPTH-1:0][WIDTH-1:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
    end else if (en) begin
      sr[0] <= din;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end

  assign dout = sr[DEPTH-1];
endmodule

module mdc_commutator #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic                    frame_start,
  input  logic                    bypass,
  input  logic signed [WIDTH-1:0] line1,
  input  logic signed [WIDTH-1:0] line2,
  output logic                    out_valid,
  output logic signed [WIDTH-1:0] line1_o,
  output logic signed [WIDTH-1:0] line2_o
);
  localparam int NUM_LANES = 2;                 // lane 0 = S1, lane 1 = S2
  localparam int CW        = $clog2(2 * DEPTH); // phase counter width
  localparam int PW        = $clog2(DEPTH + 1); // priming counter width

  typedef struct packed {
    logic [WIDTH-1:0] l1;
    logic [WIDTH-1:0] l2;
  } pair_t;

  logic [NUM_LANES-1:0][WIDTH-1:0] lane_din;
  logic [NUM_LANES-1:0][WIDTH-1:0] lane_dout;

  logic [CW-1:0]    cnt, cnt_eff;
  logic [PW-1:0]    pcnt;
  logic             primed;
  logic             sel;
  logic [WIDTH-1:0] y2, u, v;
  pair_t            out_q;
  logic             vld_q;

  // frame_start only takes effect on an accepted sample; it makes this
  // sample phase 0 rather than waiting for the counter to wrap.
  assign cnt_eff = (in_valid && frame_start) ? '0 : cnt;
  assign sel     = (cnt_eff >= CW'(DEPTH));
  assign primed  = (pcnt == PW'(DEPTH));

  // S2 tail is line2 from DEPTH accepted samples ago.
  assign y2 = lane_dout[1];
  assign u  = sel ? y2 : line1;
  assign v  = sel ? line1 : y2;

  assign lane_din[0] = u;
  assign lane_din[1] = line2;

  // Both delay lines advance on every accepted sample, bypass or not, so
  // leaving bypass resumes with consistent pairing.
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    mdc_dline #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_dline (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (in_valid),
      .din   (lane_din[g]),
      .dout  (lane_dout[g])
    );
  end

  // 2*DEPTH is a power of two, so the counter wraps on its own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        cnt <= '0;
    else if (in_valid) cnt <= cnt_eff + CW'(1);
  end

  // Saturates at DEPTH; frame_start does not touch it since stored data
  // is not flushed on re-sync.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   pcnt <= '0;
    else if (in_valid && !primed) pcnt <= pcnt + PW'(1);
  end

  // Output register holds its value through bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
      vld_q <= 1'b0;
    end else if (in_valid) begin
      if (bypass) begin
        out_q <= '{l1: line1, l2: line2};
        vld_q <= 1'b1;
      end else begin
        out_q <= '{l1: lane_dout[0], l2: v};
        vld_q <= primed;
      end
    end else begin
      vld_q <= 1'b0;
    end
  end

  assign out_valid = vld_q;
  assign line1_o   = out_q.l1;
  assign line2_o   = out_q.l2;
endmodule

// File: tb/tb_mdc_commutator.sv
// ---------------------------------------------------------------------------
// tb_mdc_commutator
//   Drives a DEPTH=4 and a DEPTH=1 commutator with the same stimulus. A
//   reference model derived from the pairing rules (sample histories, phase
//   index) pushes expected pairs into per-instance queues; a negedge monitor
//   pops and compares whenever out_valid is high, and checks the outputs
//   hold between valid pulses.
// ---------------------------------------------------------------------------
module tb_mdc_commutator;
  localparam int W = 12;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                in_valid = 1'b0, frame_start = 1'b0, bypass = 1'b0;
  logic signed [W-1:0] line1 = '0, line2 = '0;
  logic                ov4, ov1;
  logic signed [W-1:0] a4, b4, a1, b1;

  always #5 clk = ~clk;

  mdc_commutator #(.WIDTH(W), .DEPTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .frame_start(frame_start),
    .bypass(bypass), .line1(line1), .line2(line2),
    .out_valid(ov4), .line1_o(a4), .line2_o(b4));

  mdc_commutator #(.WIDTH(W), .DEPTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .frame_start(frame_start),
    .bypass(bypass), .line1(line1), .line2(line2),
    .out_valid(ov1), .line1_o(a1), .line2_o(b1));

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
  } pair_t;

  pair_t        q4[$], q1[$];
  logic [W-1:0] hl2[$];       // accepted line2 history since reset
  logic [W-1:0] hu4[$], hu1[$]; // switched upper value history per depth
  int           ph[2];        // phase index within 2*DEPTH per instance
  int           n_checks = 0, n_fail = 0;

  // Reference model: one accepted sample for both instances.
  task automatic accept(input logic [W-1:0] l1, input logic [W-1:0] l2,
                        input logic fs, input logic byp);
    int k, d, p;
    logic sel;
    logic [W-1:0] y2, ut, u, v;
    pair_t e;
    k = hl2.size();
    for (int id = 0; id < 2; id++) begin
      d = (id == 0) ? 4 : 1;
      p = fs ? 0 : ph[id];
      ph[id] = (p + 1) % (2 * d);
      sel = (p >= d);
      y2 = (k >= d) ? hl2[k-d] : '0;
      if (k >= d) ut = (id == 0) ? hu4[k-d] : hu1[k-d];
      else        ut = '0;
      u = sel ? y2 : l1;
      v = sel ? l1 : y2;
      if (id == 0) hu4.push_back(u); else hu1.push_back(u);
      e.a = byp ? l1 : ut;
      e.b = byp ? l2 : v;
      if (byp || k >= d) begin
        if (id == 0) q4.push_back(e); else q1.push_back(e);
      end
    end
    hl2.push_back(l2);
  endtask

  task automatic model_reset();
    hl2.delete(); hu4.delete(); hu1.delete(); q4.delete(); q1.delete();
    ph[0] = 0; ph[1] = 0;
  endtask

  task automatic step(input logic v, input logic fs, input logic byp,
                      input logic [W-1:0] l1, input logic [W-1:0] l2);
    @(posedge clk); #1;
    in_valid = v; frame_start = fs; bypass = byp; line1 = l1; line2 = l2;
    if (v) accept(l1, l2, fs, byp);
  endtask

  task automatic chk_zero(input string nm, input logic ov,
                          input logic [W-1:0] a, input logic [W-1:0] b);
    n_checks++;
    if (ov !== 1'b0 || a !== '0 || b !== '0) begin
      n_fail++;
      $display("FAIL %s: got valid=%0b (%0d,%0d) want valid=0 (0,0)", nm, ov, a, b);
    end
  endtask

  // Reset asserted mid-cycle while a sample is being presented; that sample
  // is discarded along with all stored state.
  task automatic pulse_reset(input logic [W-1:0] l1, input logic [W-1:0] l2);
    @(posedge clk); #1;
    in_valid = 1'b1; frame_start = 1'b0; bypass = 1'b0; line1 = l1; line2 = l2;
    #6 rst_n = 1'b0;
    #1;
    chk_zero("async_reset_d4", ov4, a4, b4);
    chk_zero("async_reset_d1", ov1, a1, b1);
    model_reset();
    in_valid = 1'b0;
    @(negedge clk); #2 rst_n = 1'b1;
  endtask

  // Monitor / scoreboard.
  pair_t last[2];
  logic  armed[2] = '{1'b0, 1'b0};

  always @(negedge clk) begin
    logic ov;
    logic [W-1:0] a, b;
    pair_t e;
    for (int id = 0; id < 2; id++) begin
      ov = (id == 0) ? ov4 : ov1;
      a  = (id == 0) ? a4  : a1;
      b  = (id == 0) ? b4  : b1;
      if (!rst_n) begin
        armed[id] = 1'b0;
      end else if (ov) begin
        n_checks++;
        if ((id == 0 && q4.size() == 0) || (id == 1 && q1.size() == 0)) begin
          n_fail++;
          $display("FAIL pair_d%0d: got valid pair (%0d,%0d) want no output", id == 0 ? 4 : 1, a, b);
        end else begin
          e = (id == 0) ? q4.pop_front() : q1.pop_front();
          if (a !== e.a || b !== e.b) begin
            n_fail++;
            $display("FAIL pair_d%0d: got (%0d,%0d) want (%0d,%0d) at %0t",
                     id == 0 ? 4 : 1, a, b, e.a, e.b, $time);
          end
          last[id] = e;
          armed[id] = 1'b1;
        end
      end else if (armed[id]) begin
        n_checks++;
        if (a !== last[id].a || b !== last[id].b) begin
          n_fail++;
          $display("FAIL hold_d%0d: got (%0d,%0d) want (%0d,%0d) at %0t",
                   id == 0 ? 4 : 1, a, b, last[id].a, last[id].b, $time);
        end
      end
    end
  end

  initial begin
    logic v, fs, byp;
    model_reset();
    #12;
    chk_zero("reset_d4", ov4, a4, b4);
    chk_zero("reset_d1", ov1, a1, b1);
    @(negedge clk); #2 rst_n = 1'b1;

    // Continuous ramp: line1=k, line2=100+k.
    for (int k = 0; k < 20; k++) step(1, 0, 0, W'(k), W'(100 + k));
    pulse_reset('0, '0);

    // Same ramp with 3 bubbles between samples.
    for (int k = 0; k < 20; k++) begin
      step(1, 0, 0, W'(k), W'(100 + k));
      for (int g = 0; g < 3; g++) step(0, 0, 0, '0, '0);
    end
    pulse_reset('0, '0);

    // Re-sync at k=6.
    for (int k = 0; k < 16; k++) step(1, k == 6, 0, W'(k), W'(100 + k));
    pulse_reset('0, '0);

    // Bypass for k=8..9.
    for (int k = 0; k < 16; k++) step(1, 0, k == 8 || k == 9, W'(k), W'(100 + k));
    pulse_reset('0, '0);

    // Reset while k=7 is presented, then restart the ramp.
    for (int k = 0; k < 7; k++) step(1, 0, 0, W'(k), W'(100 + k));
    pulse_reset(W'(7), W'(107));
    for (int k = 0; k < 12; k++) step(1, 0, 0, W'(k), W'(100 + k));

    // Random traffic: bubbles, re-syncs (incl. without in_valid), bypass
    // once primed, occasional resets.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 399) == 0) begin
        pulse_reset(W'($urandom), W'($urandom));
      end else begin
        v   = ($urandom_range(0, 3) != 0);
        fs  = ($urandom_range(0, 15) == 0);
        byp = (hl2.size() >= 4) && ($urandom_range(0, 7) == 0);
        step(v, fs, byp, W'($urandom), W'($urandom));
      end
    end

    for (int c = 0; c < 4; c++) step(0, 0, 0, '0, '0);
    @(negedge clk); #1;
    n_checks++;
    if (q4.size() != 0) begin
      n_fail++;
      $display("FAIL drain_d4: got %0d pending pairs want 0", q4.size());
    end
    n_checks++;
    if (q1.size() != 0) begin
      n_fail++;
      $display("FAIL drain_d1: got %0d pending pairs want 0", q1.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
